// File: rtl/calc_pkg.sv
// Shared definitions for the calculator button path: widths, state encoding
// and the eight alu_op codes the button encoder can produce.
package calc_pkg;

    localparam int ALU_OP_W = 4;
    localparam int BTN_W    = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_HOLD = HOLD,
        ST_GAP  = GAP
    } state_e;

    // Named by the {l,c,r} pattern each code corresponds to
    localparam logic [ALU_OP_W-1:0] OP_BTN_000 = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_BTN_001 = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_BTN_010 = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_BTN_011 = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_BTN_100 = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_BTN_101 = 4'b1001;
    localparam logic [ALU_OP_W-1:0] OP_BTN_110 = 4'b1010;
    localparam logic [ALU_OP_W-1:0] OP_BTN_111 = 4'b0101;

endpackage

// File: rtl/calc_btn_seq_if.sv
// Request handshake into the button sequencer: valid/ready plus the alu_op code.
interface calc_btn_seq_if;
    import calc_pkg::*;

    logic                op_valid;
    logic                op_ready;
    logic [ALU_OP_W-1:0] alu_op;

    modport master (output op_valid, output alu_op, input op_ready);
    modport slave  (input op_valid, input alu_op, output op_ready);

endinterface

// File: rtl/calc_btn_lut.sv
// Combinational alu_op -> {legal, l, c, r} decoder; the inverse of the button encoder.
module calc_btn_lut
    import calc_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic                legal,
    output logic [BTN_W-1:0]    btn
);

    // Map each reachable code to its button pattern; everything else is illegal
    always_comb begin
        legal = 1'b1;
        btn   = 3'b000;
        case (alu_op)
            OP_BTN_000: btn = 3'b000;
            OP_BTN_001: btn = 3'b001;
            OP_BTN_010: btn = 3'b010;
            OP_BTN_011: btn = 3'b011;
            OP_BTN_100: btn = 3'b100;
            OP_BTN_101: btn = 3'b101;
            OP_BTN_110: btn = 3'b110;
            OP_BTN_111: btn = 3'b111;
            default: begin
                legal = 1'b0;
                btn   = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/calc_btn_seq.sv
// Replays the btnl/btnc/btnr press pattern for a requested alu_op with hold/gap timing.
// Optional encoder loopback check enabled by CALC_BTN_SEQ_LOOPBACK_CHECK_EN.
module calc_btn_seq
    import calc_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    calc_btn_seq_if.slave  op,
    output logic           btnl,
    output logic           btnc,
    output logic           btnr,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
    ,
    output logic           mismatch
`endif
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_INIT  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BTN_W-1:0]   btn_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               ready_r;
    logic               legal_s;
    logic [BTN_W-1:0]   btn_s;

    calc_btn_lut u_lut (
        .alu_op (op.alu_op),
        .legal  (legal_s),
        .btn    (btn_s)
    );

    // Sequencer FSM: every output is registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            btn_r   <= 3'b000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (op.op_valid && ready_r) begin
                        if (legal_s) begin
                            state_r <= ST_HOLD;
                            btn_r   <= btn_s;
                            cnt_r   <= HOLD_INIT;
                            busy_r  <= 1'b1;
                            ready_r <= 1'b0;
                        end else begin
                            err_r   <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == '0) begin
                        btn_r <= 3'b000;
                        if (GAP_CYCLES > 0) begin
                            state_r <= ST_GAP;
                            cnt_r   <= GAP_INIT;
                        end else begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    btn_r   <= 3'b000;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign btnl        = btn_r[2];
    assign btnc        = btn_r[1];
    assign btnr        = btn_r[0];
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign op.op_ready = ready_r;

`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
    logic [ALU_OP_W-1:0] op_r;
    logic [ALU_OP_W-1:0] enc_op_s;
    logic                mismatch_r;

    // The encoder sees the driven button nets, so any corruption on them is caught
    calc_enc u_enc (
        .btnl   (btnl),
        .btnc   (btnc),
        .btnr   (btnr),
        .alu_op (enc_op_s)
    );

    // Latch the accepted op for comparison against the encoder's view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 4'b0000;
        end else if (state_r == ST_IDLE && op.op_valid && ready_r && legal_s) begin
            op_r <= op.alu_op;
        end else begin
            op_r <= op_r;
        end
    end

    // Compare in the last hold cycle; pulse lands on the following edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_r <= 1'b0;
        end else begin
            mismatch_r <= (state_r == ST_HOLD) && (cnt_r == '0) && (enc_op_s != op_r);
        end
    end

    assign mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_calc_btn_seq.sv
// Scoreboard bench for calc_btn_seq: default timing instance plus a HOLD=1/GAP=0 instance.
module tb_calc_btn_seq;
    import calc_pkg::*;

    typedef struct packed {
        logic [2:0] btn;
        logic       busy;
        logic       done;
        logic       err;
        logic       ready;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_btn_seq_if ifa ();
    calc_btn_seq_if ifb ();

    logic btnl_a, btnc_a, btnr_a, busy_a, done_a, err_a;
    logic btnl_b, btnc_b, btnr_b, busy_b, done_b, err_b;
`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
    logic mm_a, mm_b;
`endif

    calc_btn_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk (clk), .rst_n (rst_n), .op (ifa.slave),
        .btnl (btnl_a), .btnc (btnc_a), .btnr (btnr_a),
        .busy (busy_a), .done (done_a), .err (err_a)
`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
        , .mismatch (mm_a)
`endif
    );

    calc_btn_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut0 (
        .clk (clk), .rst_n (rst_n), .op (ifb.slave),
        .btnl (btnl_b), .btnc (btnc_b), .btnr (btnr_b),
        .busy (busy_b), .done (done_b), .err (err_b)
`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
        , .mismatch (mm_b)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    obs_t q_a[$];
    obs_t q_b[$];
    bit   mon_en = 1'b0;
    int   done_cnt_a = 0, done_cnt_b = 0, err_cnt_a = 0;

    function automatic obs_t idle_obs();
        obs_t o;
        o = '{btn: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b0, ready: 1'b1};
        return o;
    endfunction

    // Expected per-cycle trace of a legal request, starting the cycle after accept
    task automatic push_seq(input bit sel, input logic [2:0] pat, input int h, input int g);
        obs_t o;
        for (int i = 0; i < h; i++) begin
            o = '{btn: pat, busy: 1'b1, done: 1'b0, err: 1'b0, ready: 1'b0};
            if (sel) q_b.push_back(o); else q_a.push_back(o);
        end
        for (int i = 0; i < g; i++) begin
            o = '{btn: 3'b000, busy: 1'b1, done: 1'b0, err: 1'b0, ready: 1'b0};
            if (sel) q_b.push_back(o); else q_a.push_back(o);
        end
        o = '{btn: 3'b000, busy: 1'b0, done: 1'b1, err: 1'b0, ready: 1'b1};
        if (sel) q_b.push_back(o); else q_a.push_back(o);
    endtask

    task automatic monitor();
        obs_t ea, eb, oa, ob;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ea = (q_a.size() > 0) ? q_a.pop_front() : idle_obs();
                eb = (q_b.size() > 0) ? q_b.pop_front() : idle_obs();
                oa = '{btn: {btnl_a, btnc_a, btnr_a}, busy: busy_a, done: done_a, err: err_a, ready: ifa.op_ready};
                ob = '{btn: {btnl_b, btnc_b, btnr_b}, busy: busy_b, done: done_b, err: err_b, ready: ifb.op_ready};
                checks++;
                if (oa !== ea) begin
                    errors++;
                    $display("FAIL seq_a t=%0t observed {btn,busy,done,err,ready}=%b expected=%b", $time, oa, ea);
                end
                checks++;
                if (ob !== eb) begin
                    errors++;
                    $display("FAIL seq_b t=%0t observed {btn,busy,done,err,ready}=%b expected=%b", $time, ob, eb);
                end
`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
                checks++;
                if ({mm_a, mm_b} !== 2'b00) begin
                    errors++;
                    $display("FAIL mismatch_idle t=%0t observed=%b expected=00", $time, {mm_a, mm_b});
                end
`endif
                if (done_a === 1'b1) done_cnt_a++;
                if (done_b === 1'b1) done_cnt_b++;
                if (err_a === 1'b1) err_cnt_a++;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({btnl_a, btnc_a, btnr_a, busy_a, done_a, err_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs observed=%b expected=000000", {btnl_a, btnc_a, btnr_a, busy_a, done_a, err_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ifa.op_ready !== 1'b1 || ifb.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready observed=%b%b expected=11", ifa.op_ready, ifb.op_ready);
        end
        ifa.alu_op = 4'b1001;
        ifa.op_valid = 1'b1;
        @(posedge clk); #1;
        ifa.op_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({btnl_a, btnc_a, btnr_a, busy_a} !== 4'b1011) begin
            errors++;
            $display("FAIL reset_prehold observed=%b expected=1011", {btnl_a, btnc_a, btnr_a, busy_a});
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({btnl_a, btnc_a, btnr_a, busy_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_midhold observed=%b expected=0000", {btnl_a, btnc_a, btnr_a, busy_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ifa.op_ready, busy_a, btnl_a, btnc_a, btnr_a} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_release observed=%b expected=10000", {ifa.op_ready, busy_a, btnl_a, btnc_a, btnr_a});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_legal_default();
        int d0;
        d0 = done_cnt_a;
        ifa.alu_op = 4'b1001;
        ifa.op_valid = 1'b1;
        @(posedge clk); #1;
        push_seq(1'b0, 3'b101, 4, 2);
        ifa.alu_op = 4'b0000;
        ifa.op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cnt_a - d0 !== 1) begin
            errors++;
            $display("FAIL legal_done_count observed=%0d expected=1", done_cnt_a - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [8];
        logic [2:0] pats  [8];
        int d0;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b1001, 4'b1010, 4'b0101};
        pats  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        d0 = done_cnt_a;
        ifa.op_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifa.alu_op = codes[i];
            if (i == 0) @(posedge clk);
            else repeat (7) @(posedge clk);
            #1;
            push_seq(1'b0, pats[i], 4, 2);
            ifa.alu_op = 4'b1111;
        end
        ifa.op_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_cnt_a - d0 !== 8) begin
            errors++;
            $display("FAIL sweep_done_count observed=%0d expected=8", done_cnt_a - d0);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] bad [2];
        obs_t o;
        int d0, e0;
        bad = '{4'b0011, 4'b1111};
        d0 = done_cnt_a;
        e0 = err_cnt_a;
        for (int i = 0; i < 2; i++) begin
            ifa.alu_op = bad[i];
            ifa.op_valid = 1'b1;
            @(posedge clk); #1;
            ifa.op_valid = 1'b0;
            o = '{btn: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b1, ready: 1'b1};
            q_a.push_back(o);
            repeat (3) @(posedge clk);
            #1;
        end
        checks++;
        if (done_cnt_a - d0 !== 0 || err_cnt_a - e0 !== 2) begin
            errors++;
            $display("FAIL illegal_counts observed done=%0d err=%0d expected done=0 err=2", done_cnt_a - d0, err_cnt_a - e0);
        end
    endtask

    task automatic test_gap0();
        int d0;
        d0 = done_cnt_b;
        ifb.alu_op = 4'b0101;
        ifb.op_valid = 1'b1;
        @(posedge clk); #1;
        ifb.op_valid = 1'b0;
        push_seq(1'b1, 3'b111, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt_b - d0 !== 1) begin
            errors++;
            $display("FAIL gap0_done_count observed=%0d expected=1", done_cnt_b - d0);
        end
    endtask

`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
    task automatic test_loopback();
        int mm;
        mm = 0;
        mon_en = 1'b0;
        ifa.alu_op = 4'b0110;
        ifa.op_valid = 1'b1;
        @(posedge clk); #1;
        ifa.op_valid = 1'b0;
        force dut.btnc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mm_a === 1'b1) mm++;
        end
        release dut.btnc;
        checks++;
        if (mm !== 1) begin
            errors++;
            $display("FAIL loopback_forced observed pulses=%0d expected=1", mm);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask
`endif

    initial begin
        ifa.op_valid = 1'b0;
        ifa.alu_op = 4'b0000;
        ifb.op_valid = 1'b0;
        ifb.alu_op = 4'b0000;
        fork
            monitor();
        join_none
        test_reset();
        test_legal_default();
        test_back_to_back();
        test_illegal();
        test_gap0();
`ifdef CALC_BTN_SEQ_LOOPBACK_CHECK_EN
        test_loopback();
`endif
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q_a.size() + q_b.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", q_a.size() + q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_btn_seq.md
Name: calc_btn_seq

Overview:
- Inverse of the calculator button encoder: accepts a 4-bit alu_op request and replays the matching btnl/btnc/btnr press pattern with defined hold and release timing.
- Drives the calculator front-end from the self-test/autoplay path instead of the physical buttons.
- Rejects alu_op codes that the encoder can never produce.

Parameters:
- HOLD_CYCLES, 4: cycles the button pattern is held. Legal range ≥1.
- GAP_CYCLES, 2: cycles all buttons are released before done. Legal range ≥0.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  request valid.
- op_ready  output  1  block can accept a request; high only in IDLE.
- alu_op  input  4  requested op; sampled on accept.
- btnl  output  1  registered left-button drive.
- btnc  output  1  registered centre-button drive.
- btnr  output  1  registered right-button drive.
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse when a legal sequence completes.
- err  output  1  one-cycle pulse when an illegal code is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. btnl=btnc=btnr=0, busy=0, done=0, err=0, op_ready=1 after release. Reset mid-sequence drops the buttons immediately.
- Decode, alu_op → {l,c,r}: 0000→000, 0001→001, 0010→010, 0110→011, 0100→100, 1001→101, 1010→110, 0101→111. The other 8 codes are illegal.
- Accept: op_valid & op_ready at a rising edge.
- States: IDLE, HOLD, GAP.
- IDLE, legal accept: next cycle state=HOLD, buttons=decoded pattern, cnt=HOLD_CYCLES-1.
- IDLE, illegal accept: stays IDLE; err=1 for exactly the next cycle; buttons stay 0; no done.
- HOLD: cnt decrements each edge. At cnt==0:
  - GAP_CYCLES>0: go to GAP, buttons=0, cnt=GAP_CYCLES-1.
  - GAP_CYCLES=0: go to IDLE with buttons=0, done=1.
- GAP: at cnt==0, go to IDLE with done=1.
- Timing:
  - Buttons are high for exactly HOLD_CYCLES cycles.
  - Total busy time is HOLD_CYCLES+GAP_CYCLES cycles.
  - done and op_ready are both high in the first IDLE cycle, so back-to-back accepts lose no cycle.
- op_valid while busy is ignored: no queuing, and alu_op is not re-sampled.
- Pattern 000 (alu_op 0000) is legal. It runs the full timing with all buttons low and still pulses done.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). The latched op is held in a 4-bit register for the optional check.

Optional Feature:
- Macro: CALC_BTN_SEQ_LOOPBACK_CHECK_EN.
- When defined:
  - Adds output mismatch (1 bit).
  - The driven buttons feed an instance of the existing calc_enc.
  - In the last HOLD cycle, its alu_op is compared with the latched op. Any difference sets mismatch=1 for one cycle coincident with that cycle's following edge.
  - mismatch resets to 0.
- When undefined: no port and no calc_enc instance; behaviour is otherwise identical.

Decomposition:
- Shared package calc_pkg holds:
  - state encoding localparams (IDLE=2'd0, HOLD=2'd1, GAP=2'd2);
  - ALU_OP_W=4 and BTN_W=3;
  - the eight legal alu_op code constants, reusable by the encoder's bench.
- One natural sub-module: calc_btn_lut, a purely combinational alu_op → {legal, l, c, r} decoder. The FSM and counter stay in calc_btn_seq.

Test Plan:
- Reset: rst_n=0 mid-HOLD with pattern 101 → btnl=btnr=0 immediately; busy=0, op_ready=1 after release.
- Legal op, defaults: alu_op=1001 accepted at edge k → {l,c,r}=101 for cycles k+1..k+4; 000 for k+5..k+6; done=1 at k+7 only.
- Full sweep: all 8 legal codes back-to-back with op_valid held high → each produces its pattern; no idle gap between done and the next HOLD; 8 done pulses.
- Illegal codes: alu_op=0011, then 1111 → err=1 one cycle each; buttons stay 000; done never asserts.
- GAP_CYCLES=0, HOLD_CYCLES=1: alu_op=0101 → buttons=111 for one cycle; done the next cycle; busy high one cycle.
- Loopback check with CALC_BTN_SEQ_LOOPBACK_CHECK_EN: all legal codes → mismatch stays 0; forcing btnc low via the bench during HOLD of 0110 → mismatch=1 once.
